// File: rtl/regs_seq.sv
// regs_seq: access sequencer in front of the user register file.
// Turns one request into setup, strobe and hold cycles on the P-R2-3 bus.
module regs_seq #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter logic [15:0] INC_STEP = 16'd1
) (
  input  logic        clk_sys,
  input  logic        clr_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_h,
  input  logic [1:0]  req_a,
  input  logic        req_dst_h,
  input  logic [1:0]  req_dst_a,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_ovf,
  output logic [15:0] w,
  output logic        ra,
  output logic        rb,
  output logic        piszrn,
  output logic        czytrn,
  output logic        piszrw,
  output logic        czytrw,
  input  logic [15:0] l
);

  typedef enum logic [2:0] {
    IDLE, RSET, RSTB, WSET, WSTB, WHOLD, RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INC   = 2'd2;
  localparam logic [1:0] OP_MOVE  = 2'd3;
  localparam logic [1:0] LAST = 2'(SETUP_CYCLES - 1);

  state_t      state;
  logic [1:0]  op_q;
  logic [1:0]  cnt;
  logic        src_h_q;
  logic        dst_h_q;
  logic [1:0]  dst_a_q;
  logic        wr_h_q;
  logic        ovf_q;
  logic [16:0] sum;
  logic [2:0]  wdst;

  assign req_ready = (state == IDLE) & clr_n;
  assign sum = {1'b0, l} + {1'b0, INC_STEP};
  assign wdst = (op_q == OP_MOVE) ? {dst_h_q, dst_a_q}
                                  : {src_h_q, ra, rb};

  always_ff @(posedge clk_sys) begin
    if (!clr_n) begin
      state     <= IDLE;
      op_q      <= OP_READ;
      cnt       <= '0;
      src_h_q   <= 1'b0;
      dst_h_q   <= 1'b0;
      dst_a_q   <= '0;
      wr_h_q    <= 1'b0;
      ovf_q     <= 1'b0;
      w         <= '0;
      ra        <= 1'b0;
      rb        <= 1'b0;
      piszrn    <= 1'b0;
      czytrn    <= 1'b0;
      piszrw    <= 1'b0;
      czytrw    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            src_h_q <= req_h;
            dst_h_q <= req_dst_h;
            dst_a_q <= req_dst_a;
            ra      <= req_a[1];
            rb      <= req_a[0];
            cnt     <= '0;
            ovf_q   <= 1'b0;
            if (req_op == OP_WRITE) begin
              w      <= req_data;
              wr_h_q <= req_h;
              state  <= WSET;
            end else begin
              state  <= RSET;
            end
          end
        end
        RSET: begin
          if (cnt == LAST) begin
            czytrw <= src_h_q;
            czytrn <= ~src_h_q;
            state  <= RSTB;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RSTB: begin
          czytrw <= 1'b0;
          czytrn <= 1'b0;
          if (op_q == OP_READ) begin
            rsp_valid <= 1'b1;
            rsp_data  <= l;
            rsp_ovf   <= 1'b0;
            state     <= RESP;
          end else begin
            // Read value goes straight onto W for the write-back half.
            w      <= (op_q == OP_INC) ? sum[15:0] : l;
            ovf_q  <= (op_q == OP_INC) & sum[16];
            wr_h_q <= wdst[2];
            ra     <= wdst[1];
            rb     <= wdst[0];
            cnt    <= '0;
            state  <= WSET;
          end
        end
        WSET: begin
          if (cnt == LAST) begin
            piszrw <= wr_h_q;
            piszrn <= ~wr_h_q;
            state  <= WSTB;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        WSTB: begin
          piszrw <= 1'b0;
          piszrn <= 1'b0;
          state  <= WHOLD;
        end
        WHOLD: begin
          rsp_valid <= 1'b1;
          rsp_data  <= w;
          rsp_ovf   <= ovf_q;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_seq.sv
// tb_regs_seq: bench for regs_seq with S=1 and S=3 instances.
// Register-file model on each bus; scoreboard tracks register contents.
module tb_regs_seq;

  localparam logic [1:0] OP_R = 2'd0;
  localparam logic [1:0] OP_W = 2'd1;
  localparam logic [1:0] OP_I = 2'd2;
  localparam logic [1:0] OP_M = 2'd3;
  localparam int S0 = 1;
  localparam int S1 = 3;

  typedef struct {
    logic [1:0]  op;
    logic        h;
    logic [1:0]  a;
    logic        dh;
    logic [1:0]  da;
    logic [15:0] data;
    logic [15:0] xd;
    logic        xo;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        tb_init;
  logic [1:0]  op_i;
  logic        h_i;
  logic [1:0]  a_i;
  logic        dh_i;
  logic [1:0]  da_i;
  logic [15:0] data_i;
  logic        vld [2];
  logic        rdy [2];
  logic        rv  [2];
  logic [15:0] rsp_d [2];
  logic        ro  [2];
  logic [15:0] w_o [2];
  logic        ra_o [2];
  logic        rb_o [2];
  logic        pn [2];
  logic        cn [2];
  logic        pw [2];
  logic        cw [2];
  logic [15:0] l_i [2];

  logic [15:0] rf  [2][8];
  logic [15:0] mem [2][8];
  int checks = 0;
  int errors = 0;
  int excl_err = 0;

  always #5 clk = ~clk;

  regs_seq #(.SETUP_CYCLES(S0), .INC_STEP(16'd1)) u0 (
    .clk_sys(clk), .clr_n(clr_n),
    .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_op(op_i), .req_h(h_i), .req_a(a_i),
    .req_dst_h(dh_i), .req_dst_a(da_i), .req_data(data_i),
    .rsp_valid(rv[0]), .rsp_data(rsp_d[0]), .rsp_ovf(ro[0]),
    .w(w_o[0]), .ra(ra_o[0]), .rb(rb_o[0]),
    .piszrn(pn[0]), .czytrn(cn[0]),
    .piszrw(pw[0]), .czytrw(cw[0]),
    .l(l_i[0])
  );

  regs_seq #(.SETUP_CYCLES(S1), .INC_STEP(16'd1)) u1 (
    .clk_sys(clk), .clr_n(clr_n),
    .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_op(op_i), .req_h(h_i), .req_a(a_i),
    .req_dst_h(dh_i), .req_dst_a(da_i), .req_data(data_i),
    .rsp_valid(rv[1]), .rsp_data(rsp_d[1]), .rsp_ovf(ro[1]),
    .w(w_o[1]), .ra(ra_o[1]), .rb(rb_o[1]),
    .piszrn(pn[1]), .czytrn(cn[1]),
    .piszrw(pw[1]), .czytrw(cw[1]),
    .l(l_i[1])
  );

  // Register file: write on strobe edge, read data driven while czytr* high.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (tb_init) begin
        for (int i = 0; i < 8; i++) rf[d][i] <= 16'h0;
      end else begin
        if (pn[d]) rf[d][{1'b0, ra_o[d], rb_o[d]}] <= w_o[d];
        if (pw[d]) rf[d][{1'b1, ra_o[d], rb_o[d]}] <= w_o[d];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      l_i[d] = 16'h0;
      if (cn[d]) l_i[d] = rf[d][{1'b0, ra_o[d], rb_o[d]}];
      if (cw[d]) l_i[d] = rf[d][{1'b1, ra_o[d], rb_o[d]}];
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (int'(pn[d]) + int'(cn[d]) + int'(pw[d]) + int'(cw[d]) > 1)
        excl_err++;
      if (rv[d] && (pn[d] | cn[d] | pw[d] | cw[d]))
        excl_err++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int d, input logic [1:0] op, input logic h,
                     input logic [1:0] a, input logic dh,
                     input logic [1:0] da, input logic [15:0] data,
                     input logic [15:0] xd, input logic xo);
    int s, lat, rd_c, wr_c, k, n_rd, n_wr, rd_at, wr_at;
    bit got, stab, rdy_resp;
    logic [2:0] rd_sel, wr_sel;
    logic [2:0] dst;
    s = (d == 0) ? S0 : S1;
    dst = (op == OP_M) ? {dh, da} : {h, a};
    lat = (op == OP_R) ? s + 2 : (op == OP_W) ? s + 3 : 2 * s + 4;
    rd_c = (op == OP_W) ? 0 : s + 1;
    wr_c = (op == OP_R) ? 0 : (op == OP_W) ? s + 1 : 2 * s + 2;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdy[d];
    end
    chk("ready_wait", 32'(got), 32'd1);
    op_i = op; h_i = h; a_i = a; dh_i = dh; da_i = da;
    data_i = data;
    vld[d] = 1'b1;
    @(posedge clk);
    #1 vld[d] = 1'b0;
    k = 0; got = 0; stab = 1; rdy_resp = 0;
    n_rd = 0; n_wr = 0; rd_at = 0; wr_at = 0;
    rd_sel = '0; wr_sel = '0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (cn[d] | cw[d]) begin
        n_rd++; rd_at = k; rd_sel = {cw[d], ra_o[d], rb_o[d]};
      end
      if (pn[d] | pw[d]) begin
        n_wr++; wr_at = k; wr_sel = {pw[d], ra_o[d], rb_o[d]};
      end
      if (rd_c != 0 && k <= rd_c && {ra_o[d], rb_o[d]} != a)
        stab = 0;
      if (wr_c != 0 && k >= wr_c - s && k <= wr_c + 1 &&
          ({ra_o[d], rb_o[d]} != dst[1:0] || w_o[d] != xd))
        stab = 0;
      if (rv[d]) begin
        got = 1;
        rdy_resp = rdy[d];
      end
    end
    chk("latency", 32'(k), 32'(lat));
    chk("rsp_data", 32'(rsp_d[d]), 32'(xd));
    chk("rsp_ovf", 32'(ro[d]), 32'(xo));
    chk("ready_in_resp", 32'(rdy_resp), 32'd0);
    chk("rd_count", 32'(n_rd), (rd_c != 0) ? 32'd1 : 32'd0);
    chk("wr_count", 32'(n_wr), (wr_c != 0) ? 32'd1 : 32'd0);
    if (rd_c != 0) begin
      chk("rd_cycle", 32'(rd_at), 32'(rd_c));
      chk("rd_sel", 32'(rd_sel), 32'({h, a}));
    end
    if (wr_c != 0) begin
      chk("wr_cycle", 32'(wr_at), 32'(wr_c));
      chk("wr_sel", 32'(wr_sel), 32'(dst));
    end
    chk("bus_stable", 32'(stab), 32'd1);
    if (op != OP_R) mem[d][dst] = xd;
  endtask

  task automatic model(input int d, input logic [1:0] op,
                       input logic [2:0] src, input logic [15:0] data,
                       output logic [15:0] xd, output logic xo);
    int tmp;
    xo = 1'b0;
    case (op)
      OP_W: xd = data;
      OP_I: begin
        tmp = int'(mem[d][src]) + 1;
        xd = 16'(tmp % 65536);
        xo = (tmp > 65535);
      end
      default: xd = mem[d][src];
    endcase
  endtask

  vec_t tbl [10];

  initial begin
    int n_w, n_v, n_r;
    logic [1:0] op, a, da;
    logic h, dh, xo;
    logic [15:0] data, xd;
    int d;

    tbl[0] = '{OP_W, 1'b0, 2'd2, 1'b0, 2'd0, 16'h1234, 16'h1234, 1'b0};
    tbl[1] = '{OP_R, 1'b0, 2'd2, 1'b0, 2'd0, 16'h0000, 16'h1234, 1'b0};
    tbl[2] = '{OP_W, 1'b1, 2'd3, 1'b0, 2'd0, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[3] = '{OP_I, 1'b1, 2'd3, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1};
    tbl[4] = '{OP_W, 1'b0, 2'd0, 1'b0, 2'd0, 16'h00FF, 16'h00FF, 1'b0};
    tbl[5] = '{OP_I, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 16'h0100, 1'b0};
    tbl[6] = '{OP_W, 1'b0, 2'd1, 1'b0, 2'd0, 16'hABCD, 16'hABCD, 1'b0};
    tbl[7] = '{OP_M, 1'b0, 2'd1, 1'b1, 2'd0, 16'h0000, 16'hABCD, 1'b0};
    tbl[8] = '{OP_R, 1'b1, 2'd0, 1'b0, 2'd0, 16'h0000, 16'hABCD, 1'b0};
    tbl[9] = '{OP_R, 1'b1, 2'd3, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0};

    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < 8; i++) mem[dd][i] = 16'h0;
    clr_n = 1'b0; tb_init = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    op_i = OP_R; h_i = 0; a_i = 0; dh_i = 0; da_i = 0; data_i = 0;
    repeat (3) @(negedge clk);
    for (int dd = 0; dd < 2; dd++) begin
      chk("rst_ready_low", 32'(rdy[dd]), 32'd0);
      chk("rst_w", 32'(w_o[dd]), 32'd0);
      chk("rst_ctl", 32'({ra_o[dd], rb_o[dd], pn[dd], cn[dd], pw[dd],
                          cw[dd], rv[dd], ro[dd]}), 32'd0);
      chk("rst_rsp_data", 32'(rsp_d[dd]), 32'd0);
    end
    clr_n = 1'b1; tb_init = 1'b0;
    @(negedge clk);
    chk("rst_ready_high", 32'(rdy[0]), 32'd1);

    for (int i = 0; i < 10; i++)
      run(0, tbl[i].op, tbl[i].h, tbl[i].a, tbl[i].dh, tbl[i].da,
          tbl[i].data, tbl[i].xd, tbl[i].xo);

    // INC aborted by reset during write setup must never write back.
    run(0, OP_W, 1'b1, 2'd1, 1'b0, 2'd0, 16'h7777, 16'h7777, 1'b0);
    @(negedge clk);
    op_i = OP_I; h_i = 1'b1; a_i = 2'd1; vld[0] = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    n_w = 0; n_v = 0; n_r = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_w += int'(pn[0] | pw[0]);
      n_v += int'(rv[0]);
      n_r += int'(cn[0] | cw[0]);
      if (k == 3) clr_n = 1'b0;
      if (k == 4) begin
        chk("abort_strobes", 32'({pn[0], cn[0], pw[0], cw[0]}), 32'd0);
        chk("abort_ready_low", 32'(rdy[0]), 32'd0);
        chk("abort_rsp_data", 32'(rsp_d[0]), 32'd0);
      end
      if (k == 5) clr_n = 1'b1;
      if (k == 6) chk("abort_ready_high", 32'(rdy[0]), 32'd1);
    end
    chk("abort_no_write", 32'(n_w), 32'd0);
    chk("abort_no_rsp", 32'(n_v), 32'd0);
    chk("abort_read_once", 32'(n_r), 32'd1);
    run(0, OP_R, 1'b1, 2'd1, 1'b0, 2'd0, 16'h0, mem[0][5], 1'b0);

    run(1, OP_W, 1'b0, 2'd2, 1'b0, 2'd0, 16'h5A5A, 16'h5A5A, 1'b0);
    run(1, OP_I, 1'b0, 2'd2, 1'b0, 2'd0, 16'h0, 16'h5A5B, 1'b0);

    for (int n = 0; n < 60; n++) begin
      d = int'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      h = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      dh = 1'($urandom_range(0, 1));
      da = 2'($urandom_range(0, 3));
      data = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      model(d, op, {h, a}, data, xd, xo);
      run(d, op, h, a, dh, da, data, xd, xo);
    end

    chk("strobe_exclusive", 32'(excl_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
